lcd_nibble_reader: RTL and testbench

Reader side of the Spartan-3E character-LCD 4-bit interface. It performs HD44780 read cycles (RW=1): either a status read (RS=0, busy flag plus address counter) or a DDRAM/CGRAM data read (RS=1). It fetches the high nibble, then the low nibble, and returns one byte through a valid/ready request port.
- Sits beside the existing LCD write sequencer.
- The top level muxes E/RS/RW onto the LCD pins while bus_busy is high.

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_phase_timer.sv | 26 ++
 rtl/lcd_nibble_reader.sv | 154 +++++++++++++++
 tb/tb_lcd_nibble_reader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, timing defaults and reader state type for the character-LCD blocks
package lcd_pkg;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    // 50 MHz defaults: tAS, PW_EH, nibble cycle >= 1 us, tAH
    localparam int SETUP_CYC  = 2;
    localparam int E_HIGH_CYC = 12;
    localparam int E_LOW_CYC  = 38;
    localparam int HOLD_CYC   = 1;

    localparam int BF_BIT = 7;
    localparam int AC_MSB = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_E_HI1,
        ST_E_LO1,
        ST_E_HI2,
        ST_HOLD,
        ST_DONE
    } rd_state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// rtl/lcd_phase_timer.sv - loadable down-counter with zero flag, shared by the LCD sequencers
module lcd_phase_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_nibble_reader.sv
// rtl/lcd_nibble_reader.sv - HD44780 4-bit read cycle: status or data byte fetched as two nibbles
module lcd_nibble_reader
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC  = lcd_pkg::SETUP_CYC,
    parameter int E_HIGH_CYC = lcd_pkg::E_HIGH_CYC,
    parameter int E_LOW_CYC  = lcd_pkg::E_LOW_CYC,
    parameter int HOLD_CYC   = lcd_pkg::HOLD_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    output logic       req_ready,
    input  logic [3:0] lcd_db_in,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_db_oe,
    output logic       bus_busy,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       st_bf,
    output logic [6:0] st_ac
);

    localparam int CNT_W = $clog2(max4(SETUP_CYC, E_HIGH_CYC, E_LOW_CYC, HOLD_CYC) + 1);

    rd_state_t        state;
    logic             rs_q;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;

    lcd_phase_timer #(.WIDTH(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Timer is reloaded with the duration of the state being entered
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state)
            ST_IDLE: begin
                tmr_load = req_valid;
                tmr_val  = CNT_W'(SETUP_CYC - 1);
            end
            ST_SETUP: begin
                tmr_load = tmr_zero;
                tmr_val  = CNT_W'(E_HIGH_CYC - 1);
            end
            ST_E_HI1: begin
                tmr_load = tmr_zero;
                tmr_val  = CNT_W'(E_LOW_CYC - 1);
            end
            ST_E_LO1: begin
                tmr_load = tmr_zero;
                tmr_val  = CNT_W'(E_HIGH_CYC - 1);
            end
            ST_E_HI2: begin
                tmr_load = tmr_zero;
                tmr_val  = CNT_W'(HOLD_CYC - 1);
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rs_q      <= RS_CMD;
            req_ready <= 1'b1;
            bus_busy  <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_rw    <= 1'b0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            st_bf     <= 1'b1;
            st_ac     <= 7'h00;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        rs_q      <= req_rs;
                        lcd_rs    <= req_rs;
                        lcd_rw    <= 1'b1;
                        req_ready <= 1'b0;
                        bus_busy  <= 1'b1;
                        state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_zero) begin
                        lcd_e <= 1'b1;
                        state <= ST_E_HI1;
                    end
                end
                ST_E_HI1: begin
                    if (tmr_zero) begin
                        rd_data[7:4] <= lcd_db_in;
                        lcd_e        <= 1'b0;
                        state        <= ST_E_LO1;
                    end
                end
                ST_E_LO1: begin
                    if (tmr_zero) begin
                        lcd_e <= 1'b1;
                        state <= ST_E_HI2;
                    end
                end
                ST_E_HI2: begin
                    if (tmr_zero) begin
                        rd_data[3:0] <= lcd_db_in;
                        lcd_e        <= 1'b0;
                        state        <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tmr_zero) begin
                        lcd_rs   <= 1'b0;
                        lcd_rw   <= 1'b0;
                        rd_valid <= 1'b1;
                        // rd_data is complete here, so status fields never see a partial byte
                        if (rs_q == RS_CMD) begin
                            st_bf <= rd_data[BF_BIT];
                            st_ac <= rd_data[AC_MSB:0];
                        end
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    req_ready <= 1'b1;
                    bus_busy  <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign lcd_db_oe = 1'b0;

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// tb/tb_lcd_nibble_reader.sv - randomized self-checking bench with an LCD read-side model
module tb_lcd_nibble_reader;

    localparam int S   = 2;
    localparam int H   = 12;
    localparam int L   = 38;
    localparam int HO  = 1;
    localparam int LAT = S + 2 * H + L + HO + 1;
    localparam int TR  = LAT + 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [3:0] lcd_db_in = 4'h0;
    logic       req_ready, lcd_e, lcd_rs, lcd_rw, lcd_db_oe, bus_busy, rd_valid, st_bf;
    logic [7:0] rd_data;
    logic [6:0] st_ac;

    int         checks = 0;
    int         errors = 0;
    int         oe_bad = 0;
    int         rv_cnt = 0;
    int         e_cnt = 0;
    logic       prev_e = 1'b0;
    logic [7:0] resp = 8'h00;
    logic       exp_bf = 1'b1;
    logic [6:0] exp_ac = 7'h00;

    lcd_nibble_reader #(
        .SETUP_CYC  (S),
        .E_HIGH_CYC (H),
        .E_LOW_CYC  (L),
        .HOLD_CYC   (HO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rs    (req_rs),
        .req_ready (req_ready),
        .lcd_db_in (lcd_db_in),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_db_oe (lcd_db_oe),
        .bus_busy  (bus_busy),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .st_bf     (st_bf),
        .st_ac     (st_ac)
    );

    always #10 clk = ~clk;

    // LCD model: high nibble on odd E pulses, low nibble on even ones, noise while E is low
    always @(negedge clk) begin
        if (!bus_busy) e_cnt = 0;
        if (lcd_e && !prev_e) e_cnt = e_cnt + 1;
        prev_e = lcd_e;
        if (lcd_e) lcd_db_in = e_cnt[0] ? resp[7:4] : resp[3:0];
        else       lcd_db_in = 4'($urandom);
        if (lcd_db_oe !== 1'b0) oe_bad = oe_bad + 1;
        if (rd_valid === 1'b1) rv_cnt = rv_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic do_read(input logic rs, input logic [7:0] b, input int gap);
        logic       tr_e [0:TR];
        logic       tr_rw[0:TR];
        logic       tr_rs[0:TR];
        logic       tr_v [0:TR];
        logic       tr_bsy[0:TR];
        logic       tr_rdy[0:TR];
        int         t = 0;
        int         bad_rw = 0, bad_rs = 0, bad_bsy = 0, bad_rdy = 0;
        int         first_rw = -1, last_rw = -1, vk = -1, vcnt = 0;
        int         rises[$], falls[$];
        logic       old_bf;
        logic [6:0] old_ac;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        resp = b; req_valid = 1'b1; req_rs = rs;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        chk("req_ready_wait", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_rs = ~rs;
        old_bf = exp_bf; old_ac = exp_ac;
        if (rs == 1'b0) begin exp_bf = b[7]; exp_ac = b[6:0]; end
        tr_e[0] = 1'b0;
        for (int k = 1; k <= TR; k++) begin
            tr_e[k] = lcd_e; tr_rw[k] = lcd_rw; tr_rs[k] = lcd_rs;
            tr_v[k] = rd_valid; tr_bsy[k] = bus_busy; tr_rdy[k] = req_ready;
            if (k == LAT - 1) begin
                chk("st_bf_before", st_bf, old_bf);
                chk("st_ac_before", st_ac, old_ac);
            end
            if (k == LAT) begin
                chk("rd_data", rd_data, b);
                chk("st_bf", st_bf, exp_bf);
                chk("st_ac", st_ac, exp_ac);
            end
            if (k < TR) @(negedge clk);
        end
        chk("rd_data_hold", rd_data, b);
        for (int k = 1; k <= TR; k++) begin
            if (tr_rw[k] !== (k <= LAT - 1)) bad_rw++;
            if (k <= LAT - 1 && tr_rs[k] !== rs) bad_rs++;
            if (k >= LAT && tr_rs[k] !== 1'b0) bad_rs++;
            if (tr_bsy[k] !== (k <= LAT)) bad_bsy++;
            if (tr_rdy[k] !== (k > LAT)) bad_rdy++;
            if (tr_rw[k] && first_rw < 0) first_rw = k;
            if (tr_rw[k]) last_rw = k;
            if (tr_v[k]) begin vcnt++; if (vk < 0) vk = k; end
            if (tr_e[k] && !tr_e[k-1]) rises.push_back(k);
            if (!tr_e[k] && tr_e[k-1]) falls.push_back(k);
        end
        chk("rw_window", bad_rw, 0);
        chk("rs_window", bad_rs, 0);
        chk("busy_window", bad_bsy, 0);
        chk("ready_window", bad_rdy, 0);
        chk("rd_valid_cycle", vk, LAT);
        chk("rd_valid_count", vcnt, 1);
        chk("e_pulse_count", rises.size() * 16 + falls.size(), 2 * 16 + 2);
        if (rises.size() == 2 && falls.size() == 2) begin
            chk("e_high_1", falls[0] - rises[0], H);
            chk("e_low", rises[1] - falls[0], L);
            chk("e_high_2", falls[1] - rises[1], H);
            chk("setup", rises[0] - first_rw, S);
            chk("hold", last_rw + 1 - falls[1], HO);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int         pulses[$];
        int         rdy_between;
        int         rv_before;
        logic [3:0] bf_hist;

        repeat (3) @(negedge clk);
        chk("rst_lcd_e", lcd_e, 0);
        chk("rst_lcd_rs", lcd_rs, 0);
        chk("rst_lcd_rw", lcd_rw, 0);
        chk("rst_busy", bus_busy, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_st_bf", st_bf, 1);
        chk("rst_st_ac", st_ac, 0);
        rst = 1'b0;

        do_read(1'b0, 8'h85, 1);
        do_read(1'b1, 8'h53, 0);

        for (int i = 0; i < 10; i++)
            do_read(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3));

        bf_hist = 4'h0;
        for (int i = 0; i < 4; i++) begin
            do_read(1'b0, (i < 3) ? 8'(8'hC0 + i) : 8'h47, 0);
            bf_hist = {bf_hist[2:0], st_bf};
        end
        chk("bf_poll_seq", bf_hist, 4'b1110);

        do_read(1'b0, 8'h80, 0);
        @(negedge clk);
        resp = 8'h2A; req_valid = 1'b1; req_rs = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (28) @(negedge clk);
        chk("pre_rst_in_e_lo", {lcd_rw, lcd_e}, 2'b10);
        rv_before = rv_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_bf = 1'b1; exp_ac = 7'h00;
        chk("mid_rst_lcd_e", lcd_e, 0);
        chk("mid_rst_lcd_rw", lcd_rw, 0);
        chk("mid_rst_busy", bus_busy, 0);
        chk("mid_rst_ready", req_ready, 1);
        repeat (80) @(negedge clk);
        chk("mid_rst_no_valid", rv_cnt - rv_before, 0);
        chk("mid_rst_st_bf", st_bf, exp_bf);
        chk("mid_rst_st_ac", st_ac, exp_ac);

        @(negedge clk);
        resp = 8'h53; req_rs = 1'b1; req_valid = 1'b1;
        rdy_between = 0;
        for (int k = 0; k < 300; k++) begin
            if (rd_valid) pulses.push_back(k);
            if (req_ready && pulses.size() == 1) rdy_between++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_pulse_count", pulses.size() >= 3, 1);
        if (pulses.size() >= 3) begin
            chk("b2b_gap_1", pulses[1] - pulses[0], LAT + 1);
            chk("b2b_gap_2", pulses[2] - pulses[1], LAT + 1);
        end
        chk("b2b_ready_cycles", rdy_between, 1);
        chk("b2b_rd_data", rd_data, 8'h53);
        chk("b2b_st_ac", st_ac, exp_ac);
        repeat (80) @(negedge clk);
        chk("final_idle", {bus_busy, req_ready}, 2'b01);

        chk("db_oe_never", oe_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
